// File: rtl/shift_reg_sequencer_pkg.sv
// Shared state type, direction encodings and default width for the
// shift-register sequencer and its bench.
package shift_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Command and response handshake bundle between a requester (master)
// and the shift-register sequencer (slave).
interface shift_seq_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_dir, cmd_count, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_count, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/shift_reg_sequencer_bit_counter.sv
// Loadable down-counter; tc flags the final enabled cycle (count == 1)
// so the sequencer can leave SHIFT on that same edge.
module shift_bit_counter
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for a bidirectional serial shift register:
// shifts the latched payload in LSB first, then returns a parallel snapshot.
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk1,
  input  logic             rst_n,
  shift_seq_if.slave       host,
  output logic             sr_dir,
  output logic             sr_sin,
  output logic             sr_en,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_t       state;
  seq_state_t       state_next;
  logic             cmd_fire;
  logic             last_shift;
  logic             dir_q;
  logic [CNT_W-1:0] eff_count;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rsp_q;
  logic [IDX_W-1:0] idx;

  assign cmd_fire  = host.cmd_valid && (state == IDLE);
  // Requests longer than the register are clamped; extra payload bits do not exist.
  assign eff_count = (host.cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : host.cmd_count;

  shift_bit_counter #(.CNT_W(CNT_W)) u_counter (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .load     (cmd_fire),
    .load_val (eff_count),
    .dec      (state == SHIFT),
    .tc       (last_shift)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = (eff_count != '0) ? SHIFT : SETTLE;
      SHIFT:   if (last_shift) state_next = SETTLE;
      SETTLE:  state_next = RESP;
      RESP:    if (host.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode only registered state, so no input reaches sr_* combinationally.
  always_comb begin
    host.cmd_ready = (state == IDLE);
    host.rsp_valid = (state == RESP);
    busy           = (state != IDLE);
    sr_en          = (state == SHIFT);
    sr_dir         = (state == SHIFT) ? dir_q : DIR_LEFT;
    sr_sin         = (state == SHIFT) ? data_q[idx] : 1'b0;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= DIR_LEFT;
      data_q <= '0;
      idx    <= '0;
      rsp_q  <= '0;
    end else begin
      if (cmd_fire) begin
        dir_q  <= host.cmd_dir;
        data_q <= host.cmd_data;
        idx    <= '0;
      end else if (state == SHIFT) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == SETTLE) begin
        rsp_q <= sr_q;
      end
    end
  end

  assign host.rsp_data = rsp_q;

endmodule
